// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: multiply and fast-path divide finish 2 cycles after start, normal divide 33.
// No backpressure: start is accepted only in IDLE. flush aborts without a done pulse.
module muldiv_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_result
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_op;
  logic [31:0] r_a, r_b, r_rem, r_quo, r_result;
  logic [5:0]  r_cnt;

  // Launch-time decode on the live operands
  logic        w_launch, w_in_signed, w_fast;
  logic [31:0] w_in_a_mag;
  assign w_launch    = i_start && !i_flush;
  assign w_in_signed = !i_funct3[0];
  assign w_fast      = i_funct3[2] && ((i_src_b == 32'h0) ||
                       (w_in_signed && i_src_a == 32'h8000_0000 && i_src_b == 32'hFFFF_FFFF));
  assign w_in_a_mag  = (w_in_signed && i_src_a[31]) ? -i_src_a : i_src_a;

  // Multiply on 33-bit extended operands, widened to 64 so the low 64 product bits are exact
  logic        w_a_sgn, w_b_sgn;
  logic [63:0] w_a_ext, w_b_ext, w_prod;
  logic [31:0] w_fast_res, w_mul_res;
  assign w_a_sgn    = (r_op[1:0] != 2'b11);
  assign w_b_sgn    = !r_op[1];
  assign w_a_ext    = {{32{w_a_sgn & r_a[31]}}, r_a};
  assign w_b_ext    = {{32{w_b_sgn & r_b[31]}}, r_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_fast_res = (r_b == 32'h0) ? (r_op[1] ? r_a : 32'hFFFF_FFFF)
                                     : (r_op[1] ? 32'h0 : 32'h8000_0000);
  assign w_mul_res  = r_op[2] ? w_fast_res :
                      (r_op[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];

  // One restoring-division step; remainder stays below the divisor so bit 32 of the diff is the borrow
  logic        w_signed, w_last, w_qbit;
  logic [31:0] w_b_mag, w_rem_new, w_quo_new, w_q_final, w_r_final;
  logic [32:0] w_shift, w_diff;
  assign w_signed  = !r_op[0];
  assign w_last    = (r_cnt == 6'(DIV_ITERS - 1));
  assign w_b_mag   = (w_signed && r_b[31]) ? -r_b : r_b;
  assign w_shift   = {r_rem, r_quo[31]};
  assign w_diff    = w_shift - {1'b0, w_b_mag};
  assign w_qbit    = !w_diff[32];
  assign w_rem_new = w_qbit ? w_diff[31:0] : w_shift[31:0];
  assign w_quo_new = {r_quo[30:0], w_qbit};
  assign w_q_final = (w_signed && (r_a[31] ^ r_b[31])) ? -w_quo_new : w_quo_new;
  assign w_r_final = (w_signed && r_a[31]) ? -w_rem_new : w_rem_new;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_state_nxt = (!i_funct3[2] || w_fast) ? S_MUL : S_DIV;
      S_MUL:   w_state_nxt = S_DONE;
      S_DIV:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= 3'b0;
      r_a      <= 32'h0;
      r_b      <= 32'h0;
      r_rem    <= 32'h0;
      r_quo    <= 32'h0;
      r_cnt    <= 6'd0;
      r_result <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (w_launch) begin
          r_op  <= i_funct3;
          r_a   <= i_src_a;
          r_b   <= i_src_b;
          r_cnt <= 6'd0;
          r_rem <= 32'h0;
          r_quo <= w_in_a_mag;
        end
        S_MUL: if (!i_flush) r_result <= w_mul_res;
        S_DIV: if (!i_flush) begin
          r_cnt <= r_cnt + 6'd1;
          r_rem <= w_rem_new;
          r_quo <= w_quo_new;
          if (w_last) r_result <= r_op[1] ? w_r_final : w_q_final;
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (r_state == S_MUL) || (r_state == S_DIV);
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;

endmodule
